// File: rtl/conv_input_loader.sv
// Frame loader for the 3x3 convolution engine: splits one valid/ready pixel
// stream across kernel memory and two window SRAMs, then runs the engine once.
module conv_input_loader #(
    parameter int unsigned KERNEL_SIZE     = 3,
    parameter int unsigned DATA_WIDTH      = 8,
    parameter int unsigned SRAM_ADDR_WIDTH = 4,
    parameter int unsigned SRAM_DEPTH      = 16
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_load,
    input  logic                       s_valid,
    input  logic [DATA_WIDTH-1:0]      s_data,
    output logic                       s_ready,
    output logic [DATA_WIDTH-1:0]      o_wdata,
    output logic                       o_kernel_we,
    output logic [5:0]                 o_kernel_addr,
    output logic                       o_win1_we,
    output logic [SRAM_ADDR_WIDTH-1:0] o_win1_addr,
    output logic                       o_win2_we,
    output logic [SRAM_ADDR_WIDTH-1:0] o_win2_addr,
    output logic                       o_conv_start,
    input  logic                       i_conv_done,
    output logic                       o_busy,
    output logic                       o_done
);

    localparam int unsigned KADDR_W = 6;
    localparam int unsigned KLAST   = KERNEL_SIZE * KERNEL_SIZE - 1;
    localparam int unsigned WLAST   = SRAM_DEPTH - 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_KERNEL,
        S_LOAD_W1,
        S_LOAD_W2,
        S_START,
        S_WAIT_CONV,
        S_DONE
    } state_t;

    state_t                     r_state;
    state_t                     w_next;
    logic [KADDR_W-1:0]         r_kcnt;
    logic [SRAM_ADDR_WIDTH-1:0] r_w1cnt;
    logic [SRAM_ADDR_WIDTH-1:0] r_w2cnt;

    logic                       w_hs;
    logic                       w_k_last;
    logic                       w_w1_last;
    logic                       w_w2_last;

    logic [DATA_WIDTH-1:0]      r_wdata;
    logic                       r_kernel_we;
    logic [KADDR_W-1:0]         r_kernel_addr;
    logic                       r_win1_we;
    logic [SRAM_ADDR_WIDTH-1:0] r_win1_addr;
    logic                       r_win2_we;
    logic [SRAM_ADDR_WIDTH-1:0] r_win2_addr;
    logic                       r_conv_start;
    logic                       r_busy;
    logic                       r_done;

    assign s_ready   = (r_state == S_LOAD_KERNEL) || (r_state == S_LOAD_W1) ||
                       (r_state == S_LOAD_W2);
    assign w_hs      = s_valid && s_ready;
    assign w_k_last  = (r_kcnt == KADDR_W'(KLAST));
    assign w_w1_last = (r_w1cnt == SRAM_ADDR_WIDTH'(WLAST));
    assign w_w2_last = (r_w2cnt == SRAM_ADDR_WIDTH'(WLAST));

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:        if (i_load) w_next = S_LOAD_KERNEL;
            S_LOAD_KERNEL: if (w_hs && w_k_last) w_next = S_LOAD_W1;
            S_LOAD_W1:     if (w_hs && w_w1_last) w_next = S_LOAD_W2;
            S_LOAD_W2:     if (w_hs && w_w2_last) w_next = S_START;
            S_START:       w_next = S_WAIT_CONV;
            S_WAIT_CONV:   if (i_conv_done) w_next = S_DONE;
            S_DONE:        w_next = S_IDLE;
            default:       w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // Per-memory address counters; each returns to 0 on its last accepted word
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_kcnt  <= '0;
            r_w1cnt <= '0;
            r_w2cnt <= '0;
        end else if (w_hs) begin
            if (r_state == S_LOAD_KERNEL)
                r_kcnt <= w_k_last ? '0 : r_kcnt + KADDR_W'(1);
            if (r_state == S_LOAD_W1)
                r_w1cnt <= w_w1_last ? '0 : r_w1cnt + SRAM_ADDR_WIDTH'(1);
            if (r_state == S_LOAD_W2)
                r_w2cnt <= w_w2_last ? '0 : r_w2cnt + SRAM_ADDR_WIDTH'(1);
        end
    end

    // Registered write port and status outputs, one cycle behind the handshake
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wdata       <= '0;
            r_kernel_we   <= 1'b0;
            r_kernel_addr <= '0;
            r_win1_we     <= 1'b0;
            r_win1_addr   <= '0;
            r_win2_we     <= 1'b0;
            r_win2_addr   <= '0;
            r_conv_start  <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
        end else begin
            r_kernel_we  <= w_hs && (r_state == S_LOAD_KERNEL);
            r_win1_we    <= w_hs && (r_state == S_LOAD_W1);
            r_win2_we    <= w_hs && (r_state == S_LOAD_W2);
            r_conv_start <= (w_next == S_START);
            r_done       <= (w_next == S_DONE);
            r_busy       <= (w_next != S_IDLE);
            if (w_hs) r_wdata <= s_data;
            if (w_hs && (r_state == S_LOAD_KERNEL)) r_kernel_addr <= r_kcnt;
            if (w_hs && (r_state == S_LOAD_W1))     r_win1_addr   <= r_w1cnt;
            if (w_hs && (r_state == S_LOAD_W2))     r_win2_addr   <= r_w2cnt;
        end
    end

    assign o_wdata       = r_wdata;
    assign o_kernel_we   = r_kernel_we;
    assign o_kernel_addr = r_kernel_addr;
    assign o_win1_we     = r_win1_we;
    assign o_win1_addr   = r_win1_addr;
    assign o_win2_we     = r_win2_we;
    assign o_win2_addr   = r_win2_addr;
    assign o_conv_start  = r_conv_start;
    assign o_busy        = r_busy;
    assign o_done        = r_done;

endmodule

// File: tb/tb_conv_input_loader.sv
// Directed bench for conv_input_loader: drives frames cycle by cycle and checks
// every write, status pulse and ready level against hand-derived expectations.
module tb_conv_input_loader;

    logic       i_clk = 1'b0;
    logic       i_rst;
    logic       i_load;
    logic       s_valid;
    logic [7:0] s_data;
    logic       s_ready;
    logic [7:0] o_wdata;
    logic       o_kernel_we;
    logic [5:0] o_kernel_addr;
    logic       o_win1_we;
    logic [3:0] o_win1_addr;
    logic       o_win2_we;
    logic [3:0] o_win2_addr;
    logic       o_conv_start;
    logic       i_conv_done;
    logic       o_busy;
    logic       o_done;

    int n_checks = 0;
    int n_pass   = 0;

    // Expected write from the previous cycle's handshake: 0 none, 1 kernel, 2 win1, 3 win2
    int         p_sel  = 0;
    int         p_addr = 0;
    logic [7:0] p_data = 8'h00;
    logic [7:0] last_data = 8'h00;

    conv_input_loader dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_load       (i_load),
        .s_valid      (s_valid),
        .s_data       (s_data),
        .s_ready      (s_ready),
        .o_wdata      (o_wdata),
        .o_kernel_we  (o_kernel_we),
        .o_kernel_addr(o_kernel_addr),
        .o_win1_we    (o_win1_we),
        .o_win1_addr  (o_win1_addr),
        .o_win2_we    (o_win2_we),
        .o_win2_addr  (o_win2_addr),
        .o_conv_start (o_conv_start),
        .i_conv_done  (i_conv_done),
        .o_busy       (o_busy),
        .o_done       (o_done)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic check_zero(input string tag);
        check({tag, ".s_ready"},  32'(s_ready), 32'd0);
        check({tag, ".k_we"},     32'(o_kernel_we), 32'd0);
        check({tag, ".w1_we"},    32'(o_win1_we), 32'd0);
        check({tag, ".w2_we"},    32'(o_win2_we), 32'd0);
        check({tag, ".k_addr"},   32'(o_kernel_addr), 32'd0);
        check({tag, ".w1_addr"},  32'(o_win1_addr), 32'd0);
        check({tag, ".w2_addr"},  32'(o_win2_addr), 32'd0);
        check({tag, ".wdata"},    32'(o_wdata), 32'd0);
        check({tag, ".start"},    32'(o_conv_start), 32'd0);
        check({tag, ".busy"},     32'(o_busy), 32'd0);
        check({tag, ".done"},     32'(o_done), 32'd0);
    endtask

    // Compare the write port against the pending expectation, then clear it
    task automatic check_writes(input string tag);
        if (p_sel != 0) last_data = p_data;
        check({tag, ".k_we"},  32'(o_kernel_we), 32'(p_sel == 1));
        check({tag, ".w1_we"}, 32'(o_win1_we), 32'(p_sel == 2));
        check({tag, ".w2_we"}, 32'(o_win2_we), 32'(p_sel == 3));
        check({tag, ".wdata"}, 32'(o_wdata), 32'(last_data));
        if (p_sel == 1) check({tag, ".k_addr"},  32'(o_kernel_addr), 32'(p_addr));
        if (p_sel == 2) check({tag, ".w1_addr"}, 32'(o_win1_addr), 32'(p_addr));
        if (p_sel == 3) check({tag, ".w2_addr"}, 32'(o_win2_addr), 32'(p_addr));
        p_sel = 0;
    endtask

    task automatic set_pending(input int idx, input logic [7:0] data);
        p_data = data;
        if (idx < 9) begin
            p_sel = 1; p_addr = idx;
        end else if (idx < 25) begin
            p_sel = 2; p_addr = idx - 9;
        end else begin
            p_sel = 3; p_addr = idx - 25;
        end
    endtask

    // One frame from an IDLE cycle. Stalls of 3 cycles follow word indices st_a/st_b;
    // abort_after >= 0 resets the DUT after that word index instead of finishing.
    task automatic run_frame(input string tag, input logic [7:0] base, input int st_a,
                             input int st_b, input int lat, input bit done_in_start,
                             input bit glitch, input int abort_after);
        logic [7:0] d;
        p_sel = 0;
        i_load = 1'b1; s_valid = 1'b0; i_conv_done = 1'b0;
        @(negedge i_clk);
        check({tag, ".idle_ready"}, 32'(s_ready), 32'd0);
        check({tag, ".idle_busy"},  32'(o_busy), 32'd0);
        step();
        i_load = 1'b0;
        for (int i = 0; i < 41; i++) begin
            d = 8'(base + 8'(i));
            s_valid = 1'b1; s_data = d;
            i_load = glitch && (i == 12);
            @(negedge i_clk);
            check({tag, ".ready"}, 32'(s_ready), 32'd1);
            check({tag, ".busy"},  32'(o_busy), 32'd1);
            check({tag, ".start_early"}, 32'(o_conv_start), 32'd0);
            check({tag, ".done_early"},  32'(o_done), 32'd0);
            check_writes(tag);
            set_pending(i, d);
            step();
            i_load = 1'b0;
            if (i == abort_after) begin
                i_rst = 1'b1; s_valid = 1'b1; s_data = 8'hEE;
                @(negedge i_clk);
                check_writes({tag, ".pre_abort"});
                step();
                i_rst = 1'b0; s_valid = 1'b0;
                @(negedge i_clk);
                check_zero({tag, ".abort"});
                last_data = 8'h00;
                step();
                return;
            end
            if (i == st_a || i == st_b) begin
                repeat (3) begin
                    s_valid = 1'b0; s_data = 8'hEE;
                    @(negedge i_clk);
                    check({tag, ".stall_ready"}, 32'(s_ready), 32'd1);
                    check_writes({tag, ".stall"});
                    step();
                end
            end
        end
        // START: last win2 write visible together with the start pulse
        s_valid = 1'b1; s_data = 8'hEE; i_conv_done = done_in_start;
        @(negedge i_clk);
        check({tag, ".start"},       32'(o_conv_start), 32'd1);
        check({tag, ".start_ready"}, 32'(s_ready), 32'd0);
        check({tag, ".start_busy"},  32'(o_busy), 32'd1);
        check({tag, ".start_done"},  32'(o_done), 32'd0);
        check_writes({tag, ".last"});
        step();
        for (int k = 0; k <= lat; k++) begin
            s_valid = 1'b0;
            i_conv_done = (k == lat);
            i_load = glitch && (k == 0);
            @(negedge i_clk);
            check({tag, ".wait_start"}, 32'(o_conv_start), 32'd0);
            check({tag, ".wait_done"},  32'(o_done), 32'd0);
            check({tag, ".wait_busy"},  32'(o_busy), 32'd1);
            check({tag, ".wait_ready"}, 32'(s_ready), 32'd0);
            check_writes({tag, ".wait"});
            step();
        end
        i_conv_done = 1'b0; i_load = 1'b0;
        @(negedge i_clk);
        check({tag, ".done"},       32'(o_done), 32'd1);
        check({tag, ".done_start"}, 32'(o_conv_start), 32'd0);
        check({tag, ".done_busy"},  32'(o_busy), 32'd1);
        check_writes({tag, ".done"});
        step();
        @(negedge i_clk);
        check({tag, ".post_done"},  32'(o_done), 32'd0);
        check({tag, ".post_busy"},  32'(o_busy), 32'd0);
        check({tag, ".post_ready"}, 32'(s_ready), 32'd0);
        check_writes({tag, ".post"});
        step();
    endtask

    initial begin
        i_rst = 1'b1; i_load = 1'b0; s_valid = 1'b1; s_data = 8'hAA; i_conv_done = 1'b0;
        repeat (2) begin
            step();
            @(negedge i_clk);
            check_zero("reset");
        end
        i_rst = 1'b0;
        step();
        @(negedge i_clk);
        check_zero("idle_valid");
        step();

        run_frame("b2b",    8'h01, -1, -1, 0, 1'b0, 1'b0, -1);
        run_frame("stall",  8'h01,  4, 19, 0, 1'b0, 1'b0, -1);
        run_frame("conv",   8'h40, -1, -1, 4, 1'b1, 1'b0, -1);
        run_frame("abort",  8'h80, -1, -1, 0, 1'b0, 1'b0, 11);
        run_frame("resume", 8'h10, -1, -1, 1, 1'b0, 1'b0, -1);
        run_frame("glitch", 8'h20, -1, -1, 2, 1'b0, 1'b1, -1);
        run_frame("second", 8'h50,  7, -1, 0, 1'b0, 1'b0, -1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/conv_input_loader.md
Name: conv_input_loader

Overview:
- Upstream feeder for the 3x3 convolution engine.
- Accepts one frame as a valid/ready pixel stream and writes it into three memories: the first KERNEL_SIZE*KERNEL_SIZE words go to kernel memory, the next SRAM_DEPTH words to window1 SRAM, the last SRAM_DEPTH words to window2 SRAM.
- Once all three memories are filled, it pulses start to the convolution engine, waits for its done, then reports frame completion.

Parameters:
- KERNEL_SIZE, 3, kernel edge length; the kernel holds KERNEL_SIZE*KERNEL_SIZE words.
- DATA_WIDTH, 8, width of pixel and kernel words.
- SRAM_ADDR_WIDTH, 4, address width of the window SRAMs.
- SRAM_DEPTH, 16, words per window SRAM.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst  in  1  synchronous reset, active high.
- i_load  in  1  begin frame load; sampled in IDLE only.
- s_valid  in  1  stream word valid.
- s_data  in  DATA_WIDTH  stream word.
- s_ready  out  1  loader accepts a word this cycle.
- o_wdata  out  DATA_WIDTH  write data, shared by all three memories.
- o_kernel_we  out  1  kernel memory write enable.
- o_kernel_addr  out  6  kernel memory write address.
- o_win1_we  out  1  window1 SRAM write enable.
- o_win1_addr  out  SRAM_ADDR_WIDTH  window1 write address.
- o_win2_we  out  1  window2 SRAM write enable.
- o_win2_addr  out  SRAM_ADDR_WIDTH  window2 write address.
- o_conv_start  out  1  one-cycle start pulse to the convolution engine.
- i_conv_done  in  1  convolution engine finished.
- o_busy  out  1  high in every state except IDLE.
- o_done  out  1  one-cycle frame-complete pulse.

Behaviour:
- Clock and reset: one clock (i_clk). Reset is synchronous and active-high (i_rst).
- Reset: state=IDLE. All outputs 0, including every address, o_wdata, s_ready, all write enables, o_conv_start, o_busy and o_done. All counters 0.
- i_rst asserted mid-frame aborts the frame at the next edge. No write enable is asserted in the following cycle. Partially written memory contents are left as they are.
- States: IDLE, LOAD_KERNEL, LOAD_W1, LOAD_W2, START, WAIT_CONV, DONE.
- IDLE -> LOAD_KERNEL when i_load=1. i_load is ignored in every other state.
- s_ready is combinational: it is 1 exactly in LOAD_KERNEL, LOAD_W1 and LOAD_W2, and does not depend on s_valid.
- A handshake occurs on a cycle with s_valid && s_ready.
- Write latency is 1 cycle. For a handshake in cycle t, the selected write enable, its address and o_wdata=s_data are registered and valid during cycle t+1.
  - Write enables are 0 in any cycle not following a handshake.
  - o_wdata holds its last value when no write is pending.
- Each memory has its own counter starting at 0 and incrementing by 1 per accepted word in its state. The counter value is the write address.
- LOAD_KERNEL -> LOAD_W1 on the handshake with kernel count = KERNEL_SIZE*KERNEL_SIZE-1 (the 9th word, address 8).
- LOAD_W1 -> LOAD_W2 on the handshake with window1 count = SRAM_DEPTH-1.
- LOAD_W2 -> START on the handshake with window2 count = SRAM_DEPTH-1.
- Counters wrap to 0 when leaving their state. A new frame starts at address 0 in every memory.
- Stalls (s_valid=0) insert no write and do not advance any counter. There is no timeout.
- START lasts exactly 1 cycle: o_conv_start=1, then -> WAIT_CONV. The last window2 write (address 15) is asserted in this same cycle and is committed at its closing edge.
- WAIT_CONV -> DONE when i_conv_done=1. i_conv_done is sampled only in WAIT_CONV and ignored in all other states, including START.
- DONE lasts 1 cycle: o_done=1, then -> IDLE. A new i_load is accepted from the cycle after DONE.
- o_conv_start and o_done are registered outputs and never assert together.
- Frame size is 41 words. The minimum frame time, from i_load to o_done, is 41 + 3 + conv latency cycles.

Test Plan:
- Reset/idle: assert i_rst for 2 cycles, release, hold s_valid=1 -> all outputs 0; s_ready=0 and no writes while in IDLE.
- Back-to-back frame: pulse i_load, stream 41 words 0x01..0x29 with s_valid held 1 -> kernel writes of addr 0..8 with data 0x01..0x09; win1 writes of addr 0..15 with data 0x0A..0x19; win2 writes of addr 0..15 with data 0x1A..0x29. Each write appears 1 cycle after its handshake. o_conv_start pulses once, in the cycle after the 41st handshake.
- Stalled stream: drop s_valid for 3 cycles after word 5 and again after word 20 -> identical address/data sequence to the back-to-back case, no extra write enables, counters frozen during stalls.
- Conv handshake: hold i_conv_done=1 during START, then 0 for 4 cycles, then 1 -> done ignored in START; o_done pulses exactly one cycle after the first sampled i_conv_done=1 in WAIT_CONV; o_busy drops with the return to IDLE.
- Mid-frame reset: assert i_rst after 12 accepted words -> at the next edge state=IDLE and all outputs 0; a following i_load frame writes from kernel addr 0.
- Ignored load and second frame: pulse i_load during LOAD_W1 and WAIT_CONV -> no effect; a second full frame after o_done restarts at address 0 in all memories.
